// File: rtl/synth_pkg.sv
// Shared synth-voice definitions: default datapath widths, phase accumulator
// state encoding and the frequency control word type.
package synth_pkg;

  localparam int unsigned SYNTH_ACC_W = 24;
  localparam int unsigned SYNTH_OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GLIDE = 2'd2
  } pa_state_t;

  typedef logic [SYNTH_ACC_W-1:0] fcw_t;

endpackage

// File: rtl/phase_glide_step.sv
// One portamento step: moves cur toward tgt by |tgt-cur| >> GLIDE_SHIFT
// (at least 1), snapping onto tgt and flagging done when close enough.
module phase_glide_step #(
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned GLIDE_SHIFT = 4
) (
  input  logic [ACC_W-1:0] cur_i,
  input  logic [ACC_W-1:0] tgt_i,
  output logic [ACC_W-1:0] nxt_o,
  output logic             done_o
);

  localparam int unsigned DW = ACC_W + 1;

  logic [DW-1:0]    diff;
  logic [DW-1:0]    diff_neg;
  logic             neg;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] step;

  // Difference is one bit wider so the sign survives full-scale swings.
  always_comb begin
    nxt_o    = cur_i;
    done_o   = 1'b0;
    diff     = {1'b0, tgt_i} - {1'b0, cur_i};
    diff_neg = DW'(0) - diff;
    neg      = diff[DW-1];
    mag      = neg ? diff_neg[ACC_W-1:0] : diff[ACC_W-1:0];
    step     = mag >> GLIDE_SHIFT;
    if (step == '0) begin
      step = ACC_W'(1);
    end
    if (mag <= step) begin
      nxt_o  = tgt_i;
      done_o = 1'b1;
    end else if (neg) begin
      nxt_o = cur_i - step;
    end else begin
      nxt_o = cur_i + step;
    end
  end

endmodule

// File: rtl/phase_acc.sv
// NCO phase accumulator feeding the waveform shapers: gated run/stop,
// hard sync and optional glide between successive frequency control words.
module phase_acc
  import synth_pkg::*;
#(
  parameter int unsigned ACC_W       = SYNTH_ACC_W,
  parameter int unsigned OUT_W       = SYNTH_OUT_W,
  parameter int unsigned GLIDE_SHIFT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sample_en,
  input  logic             i_gate,
  input  logic             i_sync,
  input  logic             i_glide_en,
  input  logic [ACC_W-1:0] i_fcw,
  input  logic             i_fcw_valid,
  output logic             o_fcw_ready,
  output logic [OUT_W-1:0] o_addr,
  output logic             o_valid,
  output logic             o_wrap
);

  pa_state_t        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] cur_q, cur_d;
  logic [ACC_W-1:0] tgt_q, tgt_d;
  logic             sync_pend_q, sync_pend_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic             fcw_xfer;
  logic [ACC_W-1:0] glide_nxt;
  logic             glide_done;

  phase_glide_step #(
    .ACC_W       (ACC_W),
    .GLIDE_SHIFT (GLIDE_SHIFT)
  ) u_glide_step (
    .cur_i  (cur_q),
    .tgt_i  (tgt_q),
    .nxt_o  (glide_nxt),
    .done_o (glide_done)
  );

  assign o_fcw_ready = (state_q != GLIDE);
  assign o_addr      = acc_q[ACC_W-1 -: OUT_W];
  assign o_valid     = valid_q;
  assign o_wrap      = wrap_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cur_q       <= '0;
      tgt_q       <= '0;
      sync_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      sync_pend_q <= sync_pend_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
    end
  end

  // Gate low dominates; the advance always uses the pre-update cur_q.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    sync_pend_d = sync_pend_q;
    valid_d     = 1'b0;
    wrap_d      = 1'b0;
    sum         = {1'b0, acc_q} + {1'b0, cur_q};
    fcw_xfer    = i_fcw_valid && o_fcw_ready;

    if (state_q == IDLE) begin
      acc_d       = '0;
      sync_pend_d = 1'b0;
      if (fcw_xfer) begin
        tgt_d = i_fcw;
        cur_d = i_fcw;
      end
      if (i_gate) begin
        state_d = RUN;
      end
    end else if (!i_gate) begin
      state_d     = IDLE;
      acc_d       = '0;
      sync_pend_d = 1'b0;
      if (fcw_xfer) begin
        tgt_d = i_fcw;
        cur_d = i_fcw;
      end else begin
        cur_d = tgt_q;
      end
    end else begin
      if (i_sample_en) begin
        valid_d = 1'b1;
        if (sync_pend_q || i_sync) begin
          acc_d       = '0;
          sync_pend_d = 1'b0;
        end else begin
          acc_d  = sum[ACC_W-1:0];
          wrap_d = sum[ACC_W];
        end
      end else if (i_sync) begin
        sync_pend_d = 1'b1;
      end

      if (state_q == RUN) begin
        if (fcw_xfer) begin
          tgt_d = i_fcw;
          if (!i_glide_en || (i_fcw == cur_q)) begin
            cur_d = i_fcw;
          end else begin
            state_d = GLIDE;
          end
        end
      end else if (i_sample_en) begin
        cur_d = glide_nxt;
        if (glide_done) begin
          state_d = RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_acc.sv
// Directed bench for phase_acc: ramp, instant/glide loads, hard sync,
// gate drop, simultaneous events and reset mid-glide.
module tb_phase_acc;
  import synth_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic        gate;
  logic        sync;
  logic        glide_en;
  logic [23:0] fcw;
  logic        fcw_valid;
  logic        fcw_ready;
  logic [15:0] addr;
  logic        valid;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;

  phase_acc dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sample_en (sample_en),
    .i_gate      (gate),
    .i_sync      (sync),
    .i_glide_en  (glide_en),
    .i_fcw       (fcw),
    .i_fcw_valid (fcw_valid),
    .o_fcw_ready (fcw_ready),
    .o_addr      (addr),
    .o_valid     (valid),
    .o_wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [23:0] prev;
    logic        mono;
    logic        arrived;

    rst_n = 1'b0; sample_en = 1'b0; gate = 1'b0; sync = 1'b0;
    glide_en = 1'b0; fcw = '0; fcw_valid = 1'b0;
    tick();
    tick();
    chk("rst_addr",  32'(addr), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_wrap",  32'(wrap), 32'h0);
    chk("rst_ready", 32'(fcw_ready), 32'h1);

    // Steady ramp
    rst_n = 1'b1; gate = 1'b1; fcw = 24'h010000; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0;
    chk("ramp_state", 32'(dut.state_q), 32'(RUN));
    for (int k = 1; k <= 256; k++) begin
      strobe();
      chk("ramp_addr",  32'(addr), 32'((k * 256) & 16'hFFFF));
      chk("ramp_valid", 32'(valid), 32'h1);
      chk("ramp_wrap",  32'(wrap), 32'(k == 256));
      tick();
      chk("ramp_gap_valid", 32'(valid), 32'h0);
      tick();
      tick();
    end

    // Instant load
    fcw = 24'h001000; fcw_valid = 1'b1;
    tick();
    chk("inst_cur0", 32'(dut.cur_q), 32'h001000);
    fcw = 24'h002000;
    tick();
    fcw_valid = 1'b0;
    chk("inst_cur1",  32'(dut.cur_q), 32'h002000);
    chk("inst_ready", 32'(fcw_ready), 32'h1);

    // Glide load
    fcw = 24'h001000; fcw_valid = 1'b1;
    tick();
    glide_en = 1'b1; fcw = 24'h002000;
    tick();
    fcw_valid = 1'b0;
    chk("glide_ready0", 32'(fcw_ready), 32'h0);
    chk("glide_tgt",    32'(dut.tgt_q), 32'h002000);
    chk("glide_hold",   32'(dut.cur_q), 32'h001000);
    strobe();
    chk("glide_step1",  32'(dut.cur_q), 32'h001100);
    mono = 1'b1; arrived = 1'b0; prev = dut.cur_q;
    for (int i = 0; i < 400 && !arrived; i++) begin
      strobe();
      if (dut.cur_q < prev || dut.cur_q > 24'h002000) mono = 1'b0;
      prev = dut.cur_q;
      if (dut.cur_q == 24'h002000) arrived = 1'b1;
      else if (fcw_ready) mono = 1'b0;
    end
    chk("glide_mono",   32'(mono), 32'h1);
    chk("glide_arrive", 32'(arrived), 32'h1);
    chk("glide_ready1", 32'(fcw_ready), 32'h1);
    chk("glide_run",    32'(dut.state_q), 32'(RUN));
    glide_en = 1'b0;

    // Hard sync
    gate = 1'b0;
    tick();
    fcw = 24'h100000; fcw_valid = 1'b1; gate = 1'b1;
    tick();
    fcw_valid = 1'b0;
    for (int k = 0; k < 8; k++) strobe();
    chk("sync_pre_addr", 32'(addr), 32'h8000);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    strobe();
    chk("sync_addr",  32'(addr), 32'h0);
    chk("sync_wrap",  32'(wrap), 32'h0);
    chk("sync_valid", 32'(valid), 32'h1);
    strobe();
    chk("sync_after", 32'(addr), 32'h1000);
    strobe();
    sync = 1'b1; sample_en = 1'b1;
    tick();
    sync = 1'b0; sample_en = 1'b0;
    chk("sync_same_addr",  32'(addr), 32'h0);
    chk("sync_same_valid", 32'(valid), 32'h1);
    strobe();
    chk("sync_same_after", 32'(addr), 32'h1000);

    // Gate drop mid-glide
    glide_en = 1'b1; fcw = 24'h200000; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0;
    chk("gd_glide", 32'(dut.state_q), 32'(GLIDE));
    for (int k = 0; k < 3; k++) strobe();
    gate = 1'b0;
    tick();
    chk("gd_state", 32'(dut.state_q), 32'(IDLE));
    chk("gd_addr",  32'(addr), 32'h0);
    chk("gd_cur",   32'(dut.cur_q), 32'h200000);
    chk("gd_ready", 32'(fcw_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      strobe();
      chk("gd_idle_valid", 32'(valid), 32'h0);
      chk("gd_idle_addr",  32'(addr), 32'h0);
    end
    glide_en = 1'b0;

    // Simultaneous FCW offer, strobe and gate fall (advance would have wrapped)
    gate = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) strobe();
    chk("sim_pre_addr", 32'(addr), 32'hE000);
    fcw = 24'h012345; fcw_valid = 1'b1; sample_en = 1'b1; gate = 1'b0;
    tick();
    fcw_valid = 1'b0; sample_en = 1'b0;
    chk("sim_cur",   32'(dut.cur_q), 32'h012345);
    chk("sim_tgt",   32'(dut.tgt_q), 32'h012345);
    chk("sim_addr",  32'(addr), 32'h0);
    chk("sim_valid", 32'(valid), 32'h0);
    chk("sim_wrap",  32'(wrap), 32'h0);
    chk("sim_state", 32'(dut.state_q), 32'(IDLE));

    // Reset mid-glide
    gate = 1'b1;
    tick();
    glide_en = 1'b1; fcw = 24'h300000; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0;
    chk("mr_ready0", 32'(fcw_ready), 32'h0);
    strobe();
    chk("mr_addr0",  32'(addr), 32'h0123);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_addr",  32'(addr), 32'h0);
    chk("mr_valid", 32'(valid), 32'h0);
    chk("mr_wrap",  32'(wrap), 32'h0);
    chk("mr_ready", 32'(fcw_ready), 32'h1);
    chk("mr_tgt",   32'(dut.tgt_q), 32'h0);
    chk("mr_cur",   32'(dut.cur_q), 32'h0);
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_acc.md
# phase_acc

Numerically controlled phase accumulator that produces the 16-bit unsigned ramp address consumed by the waveform shapers (triangle, saw, square). It advances once per sample strobe by a frequency control word (FCW). It also provides gate-controlled start/stop, hard sync, and optional exponential-style glide (portamento) between successive FCWs. The block sits between the note/voice controller (upstream) and the shaper stage (downstream, driven from `o_addr`).

## Interface
- `ACC_W`, 24, accumulator and FCW width in bits
- `OUT_W`, 16, output address width; `o_addr` = `acc[ACC_W-1 -: OUT_W]`
- `GLIDE_SHIFT`, 4, glide step = |target − current| >> GLIDE_SHIFT

- `i_clk`  in  1  system clock, single domain
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_sample_en`  in  1  one-cycle sample strobe; the accumulator advances only on these cycles
- `i_gate`  in  1  high = oscillator running; low = held at phase 0
- `i_sync`  in  1  hard-sync request pulse
- `i_glide_en`  in  1  1 = glide to a new FCW; 0 = step to it instantly
- `i_fcw`  in  ACC_W  new frequency control word (unsigned)
- `i_fcw_valid`  in  1  FCW offer
- `o_fcw_ready`  out  1  FCW accept; a transfer occurs when valid && ready
- `o_addr`  out  OUT_W  ramp address to the shaper
- `o_valid`  out  1  one-cycle pulse: `o_addr` holds a newly advanced value
- `o_wrap`  out  1  one-cycle pulse: the accumulator carried out on the last advance

## Operation
- Registers: `acc`, `cur_fcw` and `tgt_fcw` (each ACC_W bits), `sync_pend`, and `state`.
- States:
  - IDLE: gate low. `acc` = 0.
  - RUN: `cur_fcw` == `tgt_fcw`.
  - GLIDE: `cur_fcw` is converging on `tgt_fcw`.
- `o_fcw_ready` = 1 in IDLE and RUN, 0 in GLIDE. It is decoded from `state`.
- State transitions:
  - IDLE → RUN when `i_gate` = 1.
  - RUN/GLIDE → IDLE when `i_gate` = 0, taking priority over every other event. On entry to IDLE: `acc` ← 0, `cur_fcw` ← `tgt_fcw` (glide aborted), `sync_pend` ← 0.
- FCW load in IDLE: `tgt_fcw` and `cur_fcw` ← `i_fcw`. No glide is applied.
- FCW load in RUN:
  - `i_glide_en` = 0: `tgt_fcw` and `cur_fcw` ← `i_fcw`; state stays RUN.
  - `i_glide_en` = 1 and `i_fcw` ≠ `cur_fcw`: `tgt_fcw` ← `i_fcw`; state → GLIDE.
  - `i_glide_en` = 1 and `i_fcw` = `cur_fcw`: the load is a no-op; state stays RUN.
- Advance (RUN/GLIDE, `i_sample_en` = 1):
  - `{carry, acc}` ← `acc` + `cur_fcw`, modulo 2^ACC_W; `o_wrap` ← carry.
  - The advance uses the `cur_fcw` value from before any same-cycle load or glide update.
- Hard sync:
  - `i_sync` = 1 sets `sync_pend`.
  - On the next advance cycle with `sync_pend` set (which may be the same cycle as the `i_sync` pulse), `acc` ← 0, `o_wrap` ← 0, and `sync_pend` clears.
  - `i_sync` in IDLE is ignored.
- Glide update (GLIDE, on `i_sample_en`):
  - diff = `tgt_fcw` − `cur_fcw`, computed signed at ACC_W+1 bits.
  - step = |diff| >> GLIDE_SHIFT; if step = 0, step = 1.
  - If |diff| ≤ step: `cur_fcw` ← `tgt_fcw` and state → RUN. Otherwise `cur_fcw` moves toward the target by step.

## Timing
- Reset (`i_rst_n` = 0 at a clock edge): `acc`, `cur_fcw`, `tgt_fcw` = 0; `sync_pend` = 0; state = IDLE. Resulting outputs: `o_addr` = 0, `o_valid` = 0, `o_wrap` = 0, `o_fcw_ready` = 1.
- Reset mid-glide or mid-run behaves identically; nothing from before reset is retained.
- Latency: a strobe in cycle n updates `acc` at the edge closing cycle n. In cycle n+1, `o_addr` shows the new value and `o_valid` and `o_wrap` pulse.
- `o_valid` only pulses for advances in RUN/GLIDE; there is no pulse in IDLE.
- FCW acceptance takes effect at the closing edge. The first advance using the new `cur_fcw` is the next strobe after that edge.
- GLIDE → RUN: `o_fcw_ready` rises in the cycle after the final glide step.
- Back-to-back loads in RUN with `i_glide_en` = 0 are accepted every cycle; the last accepted value wins.

## Structure
- Shared package `synth_pkg` holds:
  - `ACC_W` and `OUT_W` defaults, shared with the shaper modules;
  - the state enum `pa_state_t` {IDLE, RUN, GLIDE};
  - the FCW type `fcw_t`.
- Sub-module `phase_glide_step`: combinational. Takes `cur`, `tgt` and GLIDE_SHIFT; returns the next `cur` and a `done` flag.
- Everything else stays in `phase_acc`.

## Test plan
Defaults throughout (ACC_W = 24, OUT_W = 16, GLIDE_SHIFT = 4).
- **Steady ramp:** reset; gate = 1; load 0x010000 with glide off; strobe every 4 cycles. Expect `o_addr` = 0x0100, 0x0200, … with `o_valid` one cycle after each strobe. On the 256th strobe, expect `o_addr` = 0x0000 and `o_wrap` = 1 for one cycle.
- **Instant vs glide:**
  - Glide off: in RUN at 0x001000, load 0x002000 → `cur_fcw` = 0x002000 after one edge; ready stays 1.
  - Glide on: back at 0x001000, load 0x002000 → ready = 0. First step is 0x000100 (`cur_fcw` = 0x001100). `cur_fcw` rises monotonically and reaches exactly 0x002000; ready returns to 1 the cycle after arrival.
- **Hard sync:** with `acc` = 0x800000, pulse `i_sync` 2 cycles before a strobe → on that strobe `acc` = 0, `o_addr` = 0, `o_wrap` = 0, `o_valid` = 1. Pulsing `i_sync` in the same cycle as a strobe also zeroes `acc` on that strobe.
- **Gate drop mid-glide:** drop gate during GLIDE → next cycle state = IDLE, `o_addr` = 0, `cur_fcw` = `tgt_fcw`, ready = 1. No `o_valid` pulses while in IDLE.
- **Simultaneous events:** offer FCW, strobe and gate fall in the same cycle → FCW is accepted and `cur_fcw` = new value; `acc` = 0; no `o_valid` or `o_wrap` pulse.
- **Reset mid-operation:** assert `i_rst_n` = 0 for 1 cycle during GLIDE with `acc` ≠ 0 → all outputs equal their reset values on the next cycle; `tgt_fcw` = 0.
